// File: rtl/dsp_pkg.sv
// Shared definitions for the DSP multiplier arbiter.
//   dsp_state_e : arbiter FSM states (IDLE / RUN / DRAIN)
//   DEF_A_W     : default signed A operand width
//   DEF_B_W     : default signed B operand width
//   DEF_LAT     : default issue-to-response latency in cycles
package dsp_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } dsp_state_e;

    localparam int DEF_A_W = 27;
    localparam int DEF_B_W = 18;
    localparam int DEF_LAT = 3;

endpackage

// File: rtl/dsp_rr_pick.sv
// Combinational round-robin selector.
// Searches valid_i upward starting at ptr_i, wrapping at N, and returns the
// first set position.
//   valid_i  in  N       request vector
//   ptr_i    in  IW      search start position (always < N)
//   grant_o  out N       one-hot grant, zero when valid_i is zero
//   idx_o    out IW      index of the granted position (0 when none)
module dsp_rr_pick #(
    parameter int N = 4
) (
    input  logic [N-1:0]         valid_i,
    input  logic [$clog2(N)-1:0] ptr_i,
    output logic [N-1:0]         grant_o,
    output logic [$clog2(N)-1:0] idx_o
);

    localparam int IW = $clog2(N);

    logic found;
    int   pos;

    always_comb begin
        grant_o = '0;
        idx_o   = '0;
        found   = 1'b0;
        pos     = 0;
        for (int off = 0; off < N; off++) begin
            // ptr_i < N, so a single subtraction is enough to wrap
            pos = int'(ptr_i) + off;
            if (pos >= N) begin
                pos = pos - N;
            end
            if (!found && valid_i[pos]) begin
                grant_o[pos] = 1'b1;
                idx_o        = IW'(pos);
                found        = 1'b1;
            end
        end
    end

endmodule

// File: rtl/dsp_mul_arbiter.sv
// Round-robin arbiter sharing one pipelined signed multiplier between
// N_REQ requesters.  Optional per-requester issue counters are enabled by
// defining the macro DSP_MUL_ARBITER_STATS_EN.
//
// Handshake: req_ready is a combinational grant (at most one bit) that is
// only non-zero in RUN with en=1; an operation issues in any cycle where
// req_valid[i] & req_ready[i]. A requester may withdraw req_valid at any
// time without effect. The response (rsp_valid one-hot + rsp_p) appears
// exactly LAT cycles after issue and cannot be back-pressured.
//
// Ports:
//   clk, rst              clock, synchronous active-high reset
//   en                    level enable; low stops grants and drains the pipe
//   req_valid/req_ready   per-requester valid / grant
//   req_a, req_b          packed signed operands, requester i at slice i
//   rsp_valid, rsp_p      one-hot response strobe and full-width product
//   busy                  FSM not IDLE or any pipeline stage occupied
//   dbg_state             current FSM state
//   stat_sel, stat_cnt    (macro only) issue counter read port
module dsp_mul_arbiter
    import dsp_pkg::*;
#(
    parameter int N_REQ = 4,
    parameter int A_W   = DEF_A_W,
    parameter int B_W   = DEF_B_W,
    parameter int LAT   = DEF_LAT
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        en,
    input  logic [N_REQ-1:0]            req_valid,
    output logic [N_REQ-1:0]            req_ready,
    input  logic [N_REQ*A_W-1:0]        req_a,
    input  logic [N_REQ*B_W-1:0]        req_b,
    output logic [N_REQ-1:0]            rsp_valid,
    output logic signed [A_W+B_W-1:0]   rsp_p,
    output logic                        busy,
    output logic [1:0]                  dbg_state
`ifdef DSP_MUL_ARBITER_STATS_EN
    ,
    input  logic [$clog2(N_REQ)-1:0]    stat_sel,
    output logic [31:0]                 stat_cnt
`endif
);

    localparam int IW  = $clog2(N_REQ);
    localparam int P_W = A_W + B_W;

    dsp_state_e              state_q, state_d;
    logic [IW-1:0]           ptr_q, ptr_d;
    logic [LAT-1:0]          vld_q, vld_d;
    logic [IW-1:0]           idx_q [LAT];
    logic [IW-1:0]           idx_d [LAT];
    logic [N_REQ-1:0]        pick_grant;
    logic [IW-1:0]           pick_idx;
    logic                    issue;
    logic signed [A_W-1:0]   a_sel;
    logic signed [B_W-1:0]   b_sel;
    logic signed [P_W-1:0]   final_p;

    dsp_rr_pick #(.N(N_REQ)) u_pick (
        .valid_i (req_valid),
        .ptr_i   (ptr_q),
        .grant_o (pick_grant),
        .idx_o   (pick_idx)
    );

    assign a_sel     = req_a[pick_idx*A_W +: A_W];
    assign b_sel     = req_b[pick_idx*B_W +: B_W];
    assign dbg_state = state_q;

    // FSM next state; DRAIN always falls back to IDLE before RUN again
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (en)         state_d = RUN;
            RUN:     if (!en)        state_d = DRAIN;
            DRAIN:   if (vld_q == '0) state_d = IDLE;
            default:                 state_d = IDLE;
        endcase
    end

    // Grant, issue, pointer and pipeline tag bookkeeping
    always_comb begin
        req_ready = '0;
        if (!rst && state_q == RUN && en) begin
            req_ready = pick_grant;
        end
        issue = |(req_valid & req_ready);

        ptr_d = ptr_q;
        if (issue) begin
            ptr_d = (pick_idx == IW'(N_REQ - 1)) ? '0 : pick_idx + IW'(1);
        end

        vld_d[0] = issue;
        idx_d[0] = pick_idx;
        for (int k = 1; k < LAT; k++) begin
            vld_d[k] = vld_q[k-1];
            idx_d[k] = idx_q[k-1];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            vld_q   <= '0;
            for (int k = 0; k < LAT; k++) idx_q[k] <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            vld_q   <= vld_d;
            for (int k = 0; k < LAT; k++) idx_q[k] <= idx_d[k];
        end
    end

    // Multiply datapath: operand registers, product register, optional
    // delay stages. The last stage only loads on a valid op so rsp_p holds.
    generate
        if (LAT == 1) begin : g_lat1
            logic signed [P_W-1:0] p_q, p_d;
            always_comb begin
                p_d = issue ? P_W'(a_sel) * P_W'(b_sel) : p_q;
            end
            always_ff @(posedge clk) begin
                if (rst) p_q <= '0;
                else     p_q <= p_d;
            end
            assign final_p = p_q;
        end else begin : g_latn
            logic signed [A_W-1:0] a_q, a_d;
            logic signed [B_W-1:0] b_q, b_d;
            logic signed [P_W-1:0] pd_q [1:LAT-1];
            logic signed [P_W-1:0] pd_d [1:LAT-1];
            always_comb begin
                a_d = issue ? a_sel : a_q;
                b_d = issue ? b_sel : b_q;
                pd_d[1] = P_W'(a_q) * P_W'(b_q);
                for (int k = 2; k < LAT; k++) pd_d[k] = pd_q[k-1];
                if (!vld_q[LAT-2]) pd_d[LAT-1] = pd_q[LAT-1];
            end
            always_ff @(posedge clk) begin
                if (rst) begin
                    a_q <= '0;
                    b_q <= '0;
                    for (int k = 1; k < LAT; k++) pd_q[k] <= '0;
                end else begin
                    a_q <= a_d;
                    b_q <= b_d;
                    for (int k = 1; k < LAT; k++) pd_q[k] <= pd_d[k];
                end
            end
            assign final_p = pd_q[LAT-1];
        end
    endgenerate

    // Outputs are forced quiet while rst is asserted
    always_comb begin
        rsp_valid = '0;
        if (!rst && vld_q[LAT-1]) begin
            rsp_valid[idx_q[LAT-1]] = 1'b1;
        end
        rsp_p = rst ? '0 : final_p;
        busy  = !rst && (state_q != IDLE || vld_q != '0);
    end

`ifdef DSP_MUL_ARBITER_STATS_EN
    logic [31:0] cnt_q [N_REQ];
    logic [31:0] cnt_d [N_REQ];

    always_comb begin
        for (int i = 0; i < N_REQ; i++) cnt_d[i] = cnt_q[i];
        if (issue) begin
            cnt_d[pick_idx] = cnt_q[pick_idx] + 32'd1;
        end
        stat_cnt = (int'(stat_sel) < N_REQ) ? cnt_q[stat_sel] : 32'd0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < N_REQ; i++) cnt_q[i] <= '0;
        end else begin
            for (int i = 0; i < N_REQ; i++) cnt_q[i] <= cnt_d[i];
        end
    end
`else
    // No issue counters in this build.
`endif

endmodule
